mmu_sequencer: RTL and testbench

Controller that drives one `mmu_array` instance of the same `SIZE`. It loads a weight matrix through the array's weight shift chain and commits it with a swap. It then streams activation vectors through with the per-row input skew the systolic array needs, and de-skews the per-column accumulator outputs into one aligned result vector per input vector. It sits between the TPU command/host side and the array, with valid/ready streams on both sides.

---
 rtl/mmu_sequencer.sv | 152 +++++++++++++++
 tb/tb_mmu_sequencer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmu_sequencer.sv
// Sequencer for a SIZE x SIZE weight-stationary mmu_array (SIZE >= 2): loads and swaps
// weights, feeds row-skewed activations and re-aligns column sums into one result per vector.
module mmu_sequencer #(
  parameter int SIZE = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   keep_weights,
  input  logic [15:0]            num_vectors,
  output logic                   busy,
  output logic                   done,
  input  logic                   w_valid,
  output logic                   w_ready,
  input  logic [SIZE-1:0][7:0]   w_data,
  input  logic                   x_valid,
  output logic                   x_ready,
  input  logic [SIZE-1:0][7:0]   x_data,
  output logic                   y_valid,
  input  logic                   y_ready,
  output logic [SIZE-1:0][31:0]  y_data,
  output logic                   arr_run,
  output logic                   arr_load_weight,
  output logic                   arr_swap_weights,
  output logic [SIZE-1:0][7:0]   arr_weight_in,
  output logic [SIZE-1:0][7:0]   arr_data_in,
  input  logic [SIZE-1:0][31:0]  arr_acc_out
);

  localparam int VP = 2 * SIZE - 1;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_SWAP   = 3'd2;
  localparam logic [2:0] ST_STREAM = 3'd3;
  localparam logic [2:0] ST_DRAIN  = 3'd4;

  logic [2:0]            state_r, state_s;
  logic [15:0]           remain_r, beat_cnt_r;
  logic [VP-1:0]         vp_r;
  logic                  y_valid_r, done_r;
  logic [SIZE-1:0][31:0] y_data_r, deskew_s;
  logic [SIZE-1:0][7:0]  entry_s;
  logic                  adv_s, accept_s, w_accept_s, drain_done_s;

  // The whole array/skew/deskew pipeline moves only when the output slot can take a value
  assign adv_s        = ((state_r == ST_STREAM) || (state_r == ST_DRAIN)) && (!y_valid_r || y_ready);
  assign x_ready      = (state_r == ST_STREAM) && adv_s && (remain_r != 16'd0);
  assign accept_s     = x_ready && x_valid;
  assign w_accept_s   = (state_r == ST_LOAD) && w_valid;
  assign entry_s      = accept_s ? x_data : '0;
  assign drain_done_s = (state_r == ST_DRAIN) && adv_s && (vp_r == '0);

  assign busy             = (state_r != ST_IDLE);
  assign done             = done_r;
  assign w_ready          = (state_r == ST_LOAD);
  assign arr_load_weight  = w_accept_s;
  assign arr_weight_in    = w_accept_s ? w_data : '0;
  assign arr_swap_weights = (state_r == ST_SWAP);
  assign arr_run          = adv_s;
  assign y_valid          = y_valid_r;
  assign y_data           = y_data_r;

  // Next-state selection for the job FSM
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_s = keep_weights ? ST_STREAM : ST_LOAD;
        else       state_s = ST_IDLE;
      end
      ST_LOAD: begin
        if (w_accept_s && (beat_cnt_r == 16'(SIZE - 1))) state_s = ST_SWAP;
        else                                             state_s = ST_LOAD;
      end
      ST_SWAP: state_s = ST_STREAM;
      ST_STREAM: begin
        if ((remain_r == 16'd0) || (accept_s && (remain_r == 16'd1))) state_s = ST_DRAIN;
        else                                                          state_s = ST_STREAM;
      end
      ST_DRAIN: begin
        if (drain_done_s) state_s = ST_IDLE;
        else              state_s = ST_DRAIN;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // FSM state, vector/beat counters and the done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      remain_r   <= 16'd0;
      beat_cnt_r <= 16'd0;
      done_r     <= 1'b0;
    end else begin
      state_r <= state_s;
      done_r  <= drain_done_s;
      if ((state_r == ST_IDLE) && start) remain_r <= num_vectors;
      else if (accept_s)                 remain_r <= remain_r - 16'd1;
      if (state_r == ST_IDLE)  beat_cnt_r <= 16'd0;
      else if (w_accept_s)     beat_cnt_r <= beat_cnt_r + 16'd1;
    end
  end

  // Valid pipe and the common output register; the valid tail is registered with the data
  always_ff @(posedge clk) begin
    if (rst) begin
      vp_r      <= '0;
      y_valid_r <= 1'b0;
      y_data_r  <= '0;
    end else if (adv_s) begin
      vp_r      <= {vp_r[VP-2:0], accept_s};
      y_valid_r <= vp_r[VP-1];
      y_data_r  <= deskew_s;
    end
  end

  assign arr_data_in[0] = entry_s[0];

  for (genvar r = 1; r < SIZE; r++) begin : g_skew
    logic [r-1:0][7:0] chain_r;
    // Row r input is delayed by r advance stages
    always_ff @(posedge clk) begin
      if (rst) begin
        chain_r <= '0;
      end else if (adv_s) begin
        chain_r[0] <= entry_s[r];
        for (int k = 1; k < r; k++) chain_r[k] <= chain_r[k-1];
      end
    end
    assign arr_data_in[r] = chain_r[r-1];
  end

  assign deskew_s[SIZE-1] = arr_acc_out[SIZE-1];

  for (genvar c = 0; c < SIZE - 1; c++) begin : g_deskew
    localparam int D = SIZE - 1 - c;
    logic [D-1:0][31:0] chain_r;
    // Earlier columns finish sooner, so they wait SIZE-1-c stages to line up
    always_ff @(posedge clk) begin
      if (rst) begin
        chain_r <= '0;
      end else if (adv_s) begin
        chain_r[0] <= arr_acc_out[c];
        for (int k = 1; k < D; k++) chain_r[k] <= chain_r[k-1];
      end
    end
    assign deskew_s[c] = chain_r[D-1];
  end

endmodule

// File: tb/tb_mmu_sequencer.sv
// Bench for mmu_sequencer: behavioural mmu_array beside the DUT, matrix-product reference
// results, directed jobs from the test plan plus randomized jobs with gaps and backpressure.
module tb_mmu_sequencer;
  localparam int S = 2;

  logic              clk, rst, start, keep_weights;
  logic [15:0]       num_vectors;
  logic              busy, done;
  logic              w_valid, w_ready, x_valid, x_ready, y_valid, y_ready;
  logic [S-1:0][7:0] w_data, x_data, arr_weight_in, arr_data_in;
  logic [S-1:0][31:0] y_data, arr_acc_out;
  logic              arr_run, arr_load_weight, arr_swap_weights;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  logic [7:0] wm   [S][S];
  logic [7:0] wact [S][S];
  logic [S-1:0][7:0]  xvec[$];
  logic [S-1:0][31:0] got_y[$];

  logic [7:0]  shadow [S][S];
  logic [7:0]  active [S][S];
  logic [7:0]  dreg   [S][S];
  logic [31:0] psum   [S][S];

  mmu_sequencer #(.SIZE(S)) dut (
    .clk(clk), .rst(rst), .start(start), .keep_weights(keep_weights),
    .num_vectors(num_vectors), .busy(busy), .done(done),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data),
    .y_valid(y_valid), .y_ready(y_ready), .y_data(y_data),
    .arr_run(arr_run), .arr_load_weight(arr_load_weight),
    .arr_swap_weights(arr_swap_weights), .arr_weight_in(arr_weight_in),
    .arr_data_in(arr_data_in), .arr_acc_out(arr_acc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] a_in(input int r, input int c);
    if (c == 0) return arr_data_in[r];
    else        return dreg[r][c-1];
  endfunction

  function automatic logic [31:0] p_in(input int r, input int c);
    if (r == 0) return 32'd0;
    else        return psum[r-1][c];
  endfunction

  // Behavioural weight-stationary array: data moves right, partial sums move down
  always @(posedge clk) begin
    for (int r = 0; r < S; r++) begin
      for (int c = 0; c < S; c++) begin
        if (rst) begin
          shadow[r][c] <= 8'd0;
          active[r][c] <= 8'd0;
          dreg[r][c]   <= 8'd0;
          psum[r][c]   <= 32'd0;
        end else begin
          if (arr_load_weight) begin
            if (c == 0) shadow[r][c] <= arr_weight_in[r];
            else        shadow[r][c] <= shadow[r][c-1];
          end
          if (arr_swap_weights) active[r][c] <= shadow[r][c];
          if (arr_run) begin
            dreg[r][c] <= a_in(r, c);
            psum[r][c] <= p_in(r, c) + 32'(a_in(r, c)) * 32'(active[r][c]);
          end
        end
      end
    end
  end

  always_comb begin
    arr_acc_out = '0;
    for (int c = 0; c < S; c++) arr_acc_out[c] = psum[S-1][c];
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [S-1:0][31:0] matmul(input logic [S-1:0][7:0] x);
    logic [S-1:0][31:0] res;
    for (int c = 0; c < S; c++) begin
      res[c] = 32'd0;
      for (int r = 0; r < S; r++) res[c] = res[c] + 32'(x[r]) * 32'(wact[r][c]);
    end
    return res;
  endfunction

  function automatic logic [S-1:0][7:0] mkv(input logic [7:0] a0, input logic [7:0] a1);
    return {a1, a0};
  endfunction

  function automatic logic [255:0] outs_all();
    return 256'({busy, done, w_ready, x_ready, y_valid, arr_run, arr_load_weight,
                  arr_swap_weights, y_data, arr_weight_in, arr_data_in});
  endfunction

  task automatic set_idle();
    start = 1'b0; keep_weights = 1'b0; num_vectors = 16'd0;
    w_valid = 1'b0; w_data = '0; x_valid = 1'b0; x_data = '0; y_ready = 1'b1;
  endtask

  task automatic run_job(input bit keep, input int nvec, input int gap_pct, input int bp_pct,
                         input bit stall_req, input int abort_after, input bit expect_lat);
    int xi = 0, beats = 0, stall_cnt = 0, swaps = 0, last_acc = -1, last_hs = -1, done_cyc = -1;
    bit got_done = 0, saw_wr = 0, saw_yv = 0, saw_xr = 0, stall_now, first = 1;
    int acc_edges[$];
    logic [S-1:0][31:0] exp_q[$];
    logic [S-1:0][31:0] held = '0;
    got_y.delete();
    if (!keep) begin
      for (int r = 0; r < S; r++) for (int c = 0; c < S; c++) wact[r][c] = wm[r][c];
    end
    @(negedge clk);
    start = 1'b1; keep_weights = keep; num_vectors = 16'(nvec);
    for (int it = 0; it < 3000; it++) begin
      @(negedge clk);
      start = 1'b0;
      if (first) check("busy_after_start", 256'(busy), 256'(1));
      first = 0;
      if (done) begin
        got_done = 1; done_cyc = cyc;
        check("busy_at_done", 256'(busy), 256'(0));
        break;
      end
      w_valid = (beats < S) && (int'($urandom_range(99)) >= gap_pct);
      w_data = '0;
      if (beats < S) for (int r = 0; r < S; r++) w_data[r] = wm[r][S-1-beats];
      x_valid = (xi < nvec) && (int'($urandom_range(99)) >= gap_pct);
      x_data = (xi < nvec) ? xvec[xi] : '0;
      stall_now = stall_req && y_valid && (stall_cnt < 4);
      if (stall_now) y_ready = 1'b0;
      else           y_ready = (int'($urandom_range(99)) >= bp_pct);
      #1;
      if (stall_now) begin
        if (stall_cnt == 0) held = y_data;
        else check("bp_hold", 256'(y_data), 256'(held));
        check("bp_x_ready", 256'(x_ready), 256'(0));
        stall_cnt++;
      end
      if (w_ready) saw_wr = 1;
      if (x_ready) saw_xr = 1;
      if (arr_swap_weights) swaps++;
      if (y_valid) saw_yv = 1;
      if (w_valid && w_ready) beats++;
      if (x_valid && x_ready) begin
        exp_q.push_back(matmul(xvec[xi]));
        if (expect_lat) begin
          if (last_acc >= 0) check("throughput", 256'(cyc), 256'(last_acc + 1));
          acc_edges.push_back(cyc + 1);
        end
        last_acc = cyc;
        xi++;
      end
      if (y_valid && y_ready) begin
        got_y.push_back(y_data);
        if (exp_q.size() == 0) check("y_spurious", 256'(1), 256'(0));
        else check("y_data", 256'(y_data), 256'(exp_q.pop_front()));
        if (expect_lat && acc_edges.size() > 0)
          check("latency", 256'(cyc), 256'(acc_edges.pop_front() + 2 * S - 1));
        last_hs = cyc;
      end
      if ((abort_after > 0) && (xi >= abort_after)) return;
    end
    check("done_seen", 256'(got_done), 256'(1));
    check("all_sent", 256'(xi), 256'(nvec));
    check("queue_empty", 256'(exp_q.size()), 256'(0));
    if (keep) begin
      check("keep_no_w_ready", 256'(saw_wr), 256'(0));
      check("keep_no_swap", 256'(swaps), 256'(0));
    end else begin
      check("load_beats", 256'(beats), 256'(S));
      check("load_one_swap", 256'(swaps), 256'(1));
    end
    if (nvec == 0) begin
      check("zero_no_y_valid", 256'(saw_yv), 256'(0));
      check("zero_no_x_ready", 256'(saw_xr), 256'(0));
    end else begin
      check("done_timing", 256'(done_cyc), 256'(last_hs + 1));
    end
    if (stall_req) check("bp_stall_cycles", 256'(stall_cnt), 256'(4));
    set_idle();
    @(negedge clk);
    check("done_one_cycle", 256'(done), 256'(0));
  endtask

  initial begin
    set_idle();
    rst = 1'b1;
    x_valid = 1'b1; w_valid = 1'b1; w_data = 16'hA55A; x_data = 16'h3CC3;
    repeat (3) @(negedge clk);
    check("reset_outputs", outs_all(), 256'(0));
    rst = 1'b0;
    set_idle();

    // basic job: W = [[1,2],[3,4]], x = (5,6) -> (23,34)
    wm[0][0] = 8'd1; wm[0][1] = 8'd2; wm[1][0] = 8'd3; wm[1][1] = 8'd4;
    xvec = '{mkv(8'd5, 8'd6)};
    run_job(1'b0, 1, 0, 0, 1'b0, 0, 1'b1);
    check("basic_count", 256'(got_y.size()), 256'(1));
    if (got_y.size() == 1) check("basic_y", 256'(got_y[0]), 256'({32'd34, 32'd23}));

    // back-to-back stream on the same weights
    xvec = '{mkv(8'd1, 8'd0), mkv(8'd0, 8'd1), mkv(8'd1, 8'd1)};
    run_job(1'b1, 3, 0, 0, 1'b0, 0, 1'b1);
    check("b2b_count", 256'(got_y.size()), 256'(3));
    if (got_y.size() == 3) begin
      check("b2b_y0", 256'(got_y[0]), 256'({32'd2, 32'd1}));
      check("b2b_y1", 256'(got_y[1]), 256'({32'd4, 32'd3}));
      check("b2b_y2", 256'(got_y[2]), 256'({32'd6, 32'd4}));
    end

    // four-cycle backpressure on the first result while the stream is still open
    xvec = '{mkv(8'd1, 8'd0), mkv(8'd0, 8'd1), mkv(8'd1, 8'd1),
             mkv(8'd2, 8'd0), mkv(8'd0, 8'd2), mkv(8'd3, 8'd3)};
    run_job(1'b1, 6, 0, 0, 1'b1, 0, 1'b0);
    check("bp_count", 256'(got_y.size()), 256'(6));

    xvec = '{mkv(8'd2, 8'd2)};
    run_job(1'b1, 1, 0, 0, 1'b0, 0, 1'b1);
    if (got_y.size() == 1) check("keep_y", 256'(got_y[0]), 256'({32'd12, 32'd8}));
    else check("keep_count", 256'(got_y.size()), 256'(1));

    xvec.delete();
    run_job(1'b1, 0, 0, 0, 1'b0, 0, 1'b0);

    // randomized jobs: random weights, vector gaps and output backpressure
    for (int j = 0; j < 8; j++) begin
      int n;
      n = int'($urandom_range(10, 1));
      for (int r = 0; r < S; r++) for (int c = 0; c < S; c++) wm[r][c] = 8'($urandom);
      xvec.delete();
      for (int i = 0; i < n; i++) xvec.push_back(mkv(8'($urandom), 8'($urandom)));
      run_job((j % 3) == 2, n, 30, 30, 1'b0, 0, 1'b0);
    end

    // reset with two vectors in flight, then a fresh job
    for (int r = 0; r < S; r++) for (int c = 0; c < S; c++) wm[r][c] = 8'($urandom);
    xvec.delete();
    for (int i = 0; i < 4; i++) xvec.push_back(mkv(8'($urandom), 8'($urandom)));
    run_job(1'b0, 4, 0, 0, 1'b0, 2, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midjob_reset_outputs", outs_all(), 256'(0));
    rst = 1'b0;
    set_idle();
    for (int r = 0; r < S; r++) for (int c = 0; c < S; c++) wact[r][c] = 8'd0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("after_reset_quiet", 256'({done, y_valid, busy}), 256'(0));
    end
    for (int r = 0; r < S; r++) for (int c = 0; c < S; c++) wm[r][c] = 8'($urandom);
    xvec.delete();
    for (int i = 0; i < 3; i++) xvec.push_back(mkv(8'($urandom), 8'($urandom)));
    run_job(1'b0, 3, 20, 20, 1'b0, 0, 1'b0);
    check("after_reset_count", 256'(got_y.size()), 256'(3));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
